// File: rtl/sram_arbiter_if.sv
// Bundle of requester-side and SRAM-controller-side signals for the arbiter.
// slave: the arbiter's view. master: the environment driving it.
interface sram_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              start_n;
    logic              rw;
    logic [ADDR_W-1:0] addr_out;
    logic [DATA_W-1:0] data_write;
    logic              ready;
    logic [DATA_W-1:0] data_read;
    logic              busy;
    logic              timeout_err;

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, ready, data_read,
        output rd_data, rd_valid, wr_ack, start_n, rw, addr_out, data_write,
               busy, timeout_err
    );

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, ready, data_read,
        input  rd_data, rd_valid, wr_ack, start_n, rw, addr_out, data_write,
               busy, timeout_err
    );
endinterface

// File: rtl/sram_arbiter.sv
// Arbitrates one SRAM controller between a display read port and a write port.
// Writes are only admitted during blanking; reads win ties unless the write
// has been passed over STARVE_MAX times in a row.
//
// state | meaning
// IDLE  | arbitrate; on grant latch address/direction/data
// ISSUE | start_n low for this single cycle
// WAIT  | wait for ready or timeout
module sram_arbiter #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 16,
    parameter int TIMEOUT    = 255,
    parameter int STARVE_MAX = 4
) (
    input logic           CLK,
    input logic           RESET,
    input logic           VGA_BLANK_N,
    sram_arbiter_if.slave bus
);
    localparam int CNT_W    = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam int STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    state_t              state_q, state_d;
    logic                start_n_q, start_n_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rd_valid_q, rd_valid_d;
    logic                wr_ack_q, wr_ack_d;
    logic                busy_q, busy_d;
    logic                terr_q, terr_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [CNT_W-1:0]    wcnt_q, wcnt_d;

    logic rd_elig;
    logic wr_elig;
    logic starved;

    assign rd_elig = bus.rd_req;
    assign wr_elig = bus.wr_req & ~VGA_BLANK_N;
    assign starved = (starve_q == STARVE_W'(STARVE_MAX));

    // Next-state, grant, starvation and timeout logic; all outputs are registered.
    always_comb begin
        state_d    = state_q;
        start_n_d  = 1'b1;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        rd_valid_d = 1'b0;
        wr_ack_d   = 1'b0;
        terr_d     = terr_q;
        starve_d   = starve_q;
        wcnt_d     = wcnt_q;

        if (!wr_elig) begin
            starve_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_elig && (!rd_elig || starved)) begin
                    state_d   = ST_ISSUE;
                    start_n_d = 1'b0;
                    rw_d      = 1'b0;
                    addr_d    = bus.wr_addr;
                    wdata_d   = bus.wr_data;
                    starve_d  = '0;
                end else if (rd_elig) begin
                    state_d   = ST_ISSUE;
                    start_n_d = 1'b0;
                    rw_d      = 1'b1;
                    addr_d    = bus.rd_addr;
                    if (wr_elig && !starved) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                wcnt_d  = '0;
            end
            ST_WAIT: begin
                if (bus.ready) begin
                    state_d = ST_IDLE;
                    if (rw_q) begin
                        rdata_d    = bus.data_read;
                        rd_valid_d = 1'b1;
                    end else begin
                        wr_ack_d = 1'b1;
                    end
                end else if (wcnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Abandon without a completion pulse; the still-held request
                    // is simply arbitrated again from IDLE.
                    state_d = ST_IDLE;
                    terr_d  = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            start_n_q  <= 1'b1;
            rw_q       <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            wr_ack_q   <= 1'b0;
            busy_q     <= 1'b0;
            terr_q     <= 1'b0;
            starve_q   <= '0;
            wcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            start_n_q  <= start_n_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
            wr_ack_q   <= wr_ack_d;
            busy_q     <= busy_d;
            terr_q     <= terr_d;
            starve_q   <= starve_d;
            wcnt_q     <= wcnt_d;
        end
    end

    assign bus.start_n     = start_n_q;
    assign bus.rw          = rw_q;
    assign bus.addr_out    = addr_q;
    assign bus.data_write  = wdata_q;
    assign bus.rd_data     = rdata_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.wr_ack      = wr_ack_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a scripted SRAM-controller responder plus
// hand-computed expectations for each scenario.
module tb_sram_arbiter;
    logic CLK;
    logic RESET;
    logic VGA_BLANK_N;

    sram_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus ();

    sram_arbiter #(
        .ADDR_W(20), .DATA_W(16), .TIMEOUT(255), .STARVE_MAX(4)
    ) dut (
        .CLK(CLK), .RESET(RESET), .VGA_BLANK_N(VGA_BLANK_N), .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // responder controls (written only by the main initial block)
    bit          resp_en = 1'b0;
    int          resp_delay = 3;
    logic [15:0] resp_data = 16'h0000;
    bit          inject_ready = 1'b0;
    int          resp_cnt = 0;

    // monitor counters
    int n_start = 0;
    int n_rdv = 0;
    int n_wack = 0;
    int n_overlap = 0;
    int n_log = 0;
    logic grant_rw [0:31];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // SRAM controller model: ready pulses resp_delay cycles after start_n.
    always @(negedge CLK) begin
        bus.ready = 1'b0;
        if (inject_ready) begin
            bus.ready = 1'b1;
            bus.data_read = 16'hDEAD;
        end
        if (resp_cnt > 0) begin
            resp_cnt = resp_cnt - 1;
            if (resp_cnt == 0) begin
                bus.ready = 1'b1;
                bus.data_read = resp_data;
            end
        end
        if (!bus.start_n && resp_en) resp_cnt = resp_delay;
    end

    // Count strobes and completion pulses mid-cycle.
    always @(negedge CLK) begin
        if (!RESET) begin
            if (!bus.start_n) begin
                n_start = n_start + 1;
                if (n_log < 32) begin
                    grant_rw[n_log] = bus.rw;
                    n_log = n_log + 1;
                end
            end
            if (bus.rd_valid) n_rdv = n_rdv + 1;
            if (bus.wr_ack) n_wack = n_wack + 1;
            if (bus.rd_valid && bus.wr_ack) n_overlap = n_overlap + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_pulse(input bit is_wr, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (is_wr ? bus.wr_ack : bus.rd_valid) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    int  s0, r0, w0;
    bit  seen;
    logic exp_rw;

    initial begin
        RESET = 1'b1;
        VGA_BLANK_N = 1'b1;
        bus.rd_req = 1'b0;
        bus.rd_addr = '0;
        bus.wr_req = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;

        // reset state
        tick(2);
        check("rst_start_n", bus.start_n, 1);
        check("rst_rw", bus.rw, 1);
        check("rst_addr", bus.addr_out, 0);
        check("rst_wdata", bus.data_write, 0);
        check("rst_rdata", bus.rd_data, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_wr_ack", bus.wr_ack, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_terr", bus.timeout_err, 0);
        RESET = 1'b0;
        tick(1);

        // basic read, ready 3 cycles after start_n
        resp_en = 1'b1; resp_delay = 3; resp_data = 16'hBEEF;
        r0 = n_rdv;
        bus.rd_req = 1'b1; bus.rd_addr = 20'h00123;
        tick(1);
        check("rd_start_n", bus.start_n, 0);
        check("rd_rw", bus.rw, 1);
        check("rd_addr", bus.addr_out, 20'h00123);
        check("rd_busy", bus.busy, 1);
        tick(1);
        check("rd_start_n_one", bus.start_n, 1);
        tick(3);
        check("rd_valid", bus.rd_valid, 1);
        check("rd_data", bus.rd_data, 16'hBEEF);
        check("rd_idle", bus.busy, 0);
        bus.rd_req = 1'b0;
        tick(1);
        check("rd_valid_pulse", bus.rd_valid, 0);
        check("rd_count", n_rdv - r0, 1);

        // ready outside WAIT is ignored; rd_data holds
        r0 = n_rdv; w0 = n_wack;
        inject_ready = 1'b1;
        tick(1);
        inject_ready = 1'b0;
        tick(2);
        check("ign_rdv", n_rdv - r0, 0);
        check("ign_wack", n_wack - w0, 0);
        check("ign_rdata", bus.rd_data, 16'hBEEF);

        // write gated by display-active
        resp_delay = 2;
        s0 = n_start; w0 = n_wack;
        bus.wr_req = 1'b1; bus.wr_addr = 20'h00040; bus.wr_data = 16'h000A;
        tick(20);
        check("wg_no_start", n_start - s0, 0);
        check("wg_no_busy", bus.busy, 0);
        VGA_BLANK_N = 1'b0;
        tick(1);
        check("wg_start_n", bus.start_n, 0);
        check("wg_rw", bus.rw, 0);
        check("wg_addr", bus.addr_out, 20'h00040);
        check("wg_wdata", bus.data_write, 16'h000A);
        wait_pulse(1'b1, 10, seen);
        check("wg_ack_seen", seen, 1);
        bus.wr_req = 1'b0;
        tick(3);
        check("wg_ack_count", n_wack - w0, 1);

        // starvation: R,R,R,R,W repeating
        resp_delay = 1;
        n_log = 0;
        bus.rd_req = 1'b1; bus.rd_addr = 20'h00200;
        bus.wr_req = 1'b1; bus.wr_addr = 20'h00300; bus.wr_data = 16'h1111;
        for (int i = 0; i < 200 && n_log < 10; i++) tick(1);
        bus.rd_req = 1'b0; bus.wr_req = 1'b0;
        check("st_log_len", (n_log >= 10), 1);
        for (int i = 0; i < 10; i++) begin
            exp_rw = ((i % 5) == 4) ? 1'b0 : 1'b1;
            check($sformatf("st_grant%0d", i), grant_rw[i], exp_rw);
        end
        tick(6);
        check("st_drain", bus.busy, 0);

        // timeout: no ready, abort after 255 WAIT cycles, then re-issue
        VGA_BLANK_N = 1'b1;
        resp_en = 1'b0;
        r0 = n_rdv;
        bus.rd_req = 1'b1; bus.rd_addr = 20'h00055;
        tick(1);
        check("to_start_n", bus.start_n, 0);
        tick(255);
        check("to_still_busy", bus.busy, 1);
        check("to_terr_early", bus.timeout_err, 0);
        resp_en = 1'b1; resp_delay = 2; resp_data = 16'h1234;
        tick(1);
        check("to_idle", bus.busy, 0);
        check("to_terr", bus.timeout_err, 1);
        tick(1);
        check("to_reissue", bus.start_n, 0);
        check("to_reissue_addr", bus.addr_out, 20'h00055);
        wait_pulse(1'b0, 10, seen);
        check("to_rd_seen", seen, 1);
        check("to_rdata", bus.rd_data, 16'h1234);
        bus.rd_req = 1'b0;
        tick(2);
        check("to_rdv_count", n_rdv - r0, 1);
        check("to_terr_sticky", bus.timeout_err, 1);

        // reset mid-write
        resp_en = 1'b0;
        VGA_BLANK_N = 1'b0;
        w0 = n_wack;
        bus.wr_req = 1'b1; bus.wr_addr = 20'h00077; bus.wr_data = 16'h5A5A;
        tick(4);
        check("rm_busy", bus.busy, 1);
        RESET = 1'b1;
        #1;
        check("rm_start_n", bus.start_n, 1);
        check("rm_rw", bus.rw, 1);
        check("rm_addr", bus.addr_out, 0);
        check("rm_wdata", bus.data_write, 0);
        check("rm_busy0", bus.busy, 0);
        check("rm_terr", bus.timeout_err, 0);
        check("rm_rdata", bus.rd_data, 0);
        resp_en = 1'b1; resp_delay = 2;
        tick(2);
        check("rm_no_ack", n_wack - w0, 0);
        RESET = 1'b0;
        tick(1);
        check("rm_regrant", bus.start_n, 0);
        check("rm_regrant_rw", bus.rw, 0);
        check("rm_regrant_addr", bus.addr_out, 20'h00077);
        wait_pulse(1'b1, 10, seen);
        check("rm_ack_seen", seen, 1);
        bus.wr_req = 1'b0;
        tick(2);
        check("rm_ack_count", n_wack - w0, 1);

        // blanking ends during write WAIT: completes once
        resp_delay = 5;
        s0 = n_start; w0 = n_wack;
        bus.wr_req = 1'b1; bus.wr_addr = 20'h00099; bus.wr_data = 16'h003C;
        tick(1);
        check("be_start_n", bus.start_n, 0);
        tick(2);
        VGA_BLANK_N = 1'b1;
        wait_pulse(1'b1, 15, seen);
        check("be_ack_seen", seen, 1);
        bus.wr_req = 1'b0;
        tick(5);
        check("be_ack_count", n_wack - w0, 1);
        check("be_start_count", n_start - s0, 1);
        check("be_idle", bus.busy, 0);

        check("excl_pulses", n_overlap, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
